// File: rtl/btn_event_if.sv
// Button/event and register-bus signal bundle for btn_event.
// Handshake: the bus side has no valid/ready pair; a cycle is requested by raising wb_cyc,
// and the slave answers with a single-cycle wb_ack one clock later. Read data is only
// meaningful while wb_ack=1. The button side is qualified by btn_stb: btn_val is sampled
// only in cycles where btn_stb=1.
interface btn_event_if;
    logic        btn_val;
    logic        btn_stb;
    logic        btn_state;
    logic        evt_short;
    logic        evt_long;
    logic        rst_req;
    logic        wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic [1:0]  dbg_state;

    modport master (
        output btn_val, btn_stb, wb_addr, wb_wdata, wb_we, wb_cyc,
        input  btn_state, evt_short, evt_long, rst_req, wb_rdata, wb_ack, dbg_state
    );

    modport slave (
        input  btn_val, btn_stb, wb_addr, wb_wdata, wb_we, wb_cyc,
        output btn_state, evt_short, evt_long, rst_req, wb_rdata, wb_ack, dbg_state
    );
endinterface

// File: rtl/btn_event.sv
// Button debouncer and press classifier: turns strobed raw samples into a debounced level,
// short/long release events and a reset request after a very long hold, with event
// counters readable (and clearable) over a tiny two-register bus.
module btn_event #(
    parameter int DB_LEN   = 8,
    parameter int LONG_LEN = 1000,
    parameter int RST_LEN  = 4000
) (
    input  logic        clk,
    input  logic        rst,
    btn_event_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_LONG  = 2'd2,
        S_RST   = 2'd3
    } state_t;

    localparam logic [7:0]  DB_MAX = 8'(DB_LEN - 1);
    localparam logic [15:0] LONG_V = 16'(LONG_LEN);
    localparam logic [15:0] RST_V  = 16'(RST_LEN);

    state_t      state;
    logic        btn_state;
    logic [7:0]  db_cnt;
    logic [15:0] hold_cnt;
    logic [15:0] hold_inc;
    logic        evt_short;
    logic        evt_long;
    logic        rst_req;
    logic [7:0]  short_cnt;
    logic [7:0]  long_cnt;
    logic        rst_seen;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        bus_start;
    logic        clr;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic        unused_wdata;

    // Write data carries no information: any write to address 1 is a clear.
    assign unused_wdata = ^bus.wb_wdata;

    assign hold_inc  = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
    assign bus_start = bus.wb_cyc & ~wb_ack;
    assign clr       = bus_start & bus.wb_we & bus.wb_addr;
    assign reg0      = {hold_cnt, 13'd0, state, btn_state};
    assign reg1      = {15'd0, rst_seen, long_cnt, short_cnt};

    // Debounce: a run of DB_LEN strobed samples disagreeing with the level flips it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_state <= 1'b0;
            db_cnt    <= 8'd0;
        end else if (bus.btn_stb) begin
            if (bus.btn_val == btn_state) begin
                db_cnt <= 8'd0;
            end else if (db_cnt == DB_MAX) begin
                btn_state <= ~btn_state;
                db_cnt    <= 8'd0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    // Press classifier: counts held strobes and emits one registered pulse per outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= 16'd0;
            evt_short <= 1'b0;
            evt_long  <= 1'b0;
            rst_req   <= 1'b0;
        end else begin
            evt_short <= 1'b0;
            evt_long  <= 1'b0;
            rst_req   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (btn_state) begin
                        state    <= S_PRESS;
                        hold_cnt <= 16'd0;
                    end
                end
                S_PRESS: begin
                    if (!btn_state) begin
                        evt_short <= 1'b1;
                        state     <= S_IDLE;
                    end else if (bus.btn_stb) begin
                        hold_cnt <= hold_inc;
                        if (hold_inc >= LONG_V) state <= S_LONG;
                    end
                end
                S_LONG: begin
                    if (!btn_state) begin
                        evt_long <= 1'b1;
                        state    <= S_IDLE;
                    end else if (bus.btn_stb) begin
                        hold_cnt <= hold_inc;
                        if (hold_inc >= RST_V) begin
                            rst_req <= 1'b1;
                            state   <= S_RST;
                        end
                    end
                end
                S_RST: begin
                    // The reset request already fired; the release is silent.
                    if (!btn_state) begin
                        state <= S_IDLE;
                    end else if (bus.btn_stb) begin
                        hold_cnt <= hold_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Event statistics; a clear colliding with an event keeps that event's count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_cnt <= 8'd0;
            long_cnt  <= 8'd0;
            rst_seen  <= 1'b0;
        end else if (clr) begin
            short_cnt <= evt_short ? 8'd1 : 8'd0;
            long_cnt  <= evt_long  ? 8'd1 : 8'd0;
            rst_seen  <= rst_req;
        end else begin
            if (evt_short && short_cnt != 8'hFF) short_cnt <= short_cnt + 8'd1;
            if (evt_long  && long_cnt  != 8'hFF) long_cnt  <= long_cnt + 8'd1;
            if (rst_req) rst_seen <= 1'b1;
        end
    end

    // Bus responder: ack one cycle after cyc, read data only alongside ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_rdata <= 32'd0;
        end else begin
            wb_ack   <= bus_start;
            wb_rdata <= bus_start ? (bus.wb_addr ? reg1 : reg0) : 32'd0;
        end
    end

    assign bus.btn_state = btn_state;
    assign bus.evt_short = evt_short;
    assign bus.evt_long  = evt_long;
    assign bus.rst_req   = rst_req;
    assign bus.wb_ack    = wb_ack;
    assign bus.wb_rdata  = wb_rdata;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: strobe-level reference model predicts events and register
// contents; a negedge monitor pops the expected queues whenever the DUT pulses an event
// or acknowledges a bus cycle.
module tb_btn_event;
    localparam int DB_LEN   = 8;
    localparam int LONG_LEN = 1000;
    localparam int RST_LEN  = 4000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    btn_event_if bus ();

    btn_event #(.DB_LEN(DB_LEN), .LONG_LEN(LONG_LEN), .RST_LEN(RST_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // expected event codes: 1 short, 2 long, 3 reset request
    logic [1:0]  exp_q[$];
    // bit 32 set: compare read data; clear: write, data ignored
    logic [32:0] exp_rd_q[$];

    // reference model, one update per strobe
    int m_deb;
    int m_run;
    int m_n;
    int m_short;
    int m_long;
    int m_rseen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_deb = 0; m_run = 0; m_n = 0;
        m_short = 0; m_long = 0; m_rseen = 0;
    endtask

    task automatic model_strobe(input bit v);
        if (m_deb == 1) begin
            if (m_n < 65535) m_n++;
            if (m_n == RST_LEN) begin
                exp_q.push_back(2'd3);
                m_rseen = 1;
            end
        end
        if (int'(v) == m_deb) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DB_LEN) begin
                m_run = 0;
                m_deb = int'(v);
                if (v) begin
                    m_n = 0;
                end else if (m_n < LONG_LEN) begin
                    exp_q.push_back(2'd1);
                    if (m_short < 255) m_short++;
                end else if (m_n < RST_LEN) begin
                    exp_q.push_back(2'd2);
                    if (m_long < 255) m_long++;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_addr0();
        logic [1:0] st;
        if (m_deb == 0)           st = 2'd0;
        else if (m_n < LONG_LEN)  st = 2'd1;
        else if (m_n < RST_LEN)   st = 2'd2;
        else                      st = 2'd3;
        return {16'(m_n), 13'd0, st, 1'(m_deb)};
    endfunction

    function automatic logic [31:0] m_addr1();
        return {15'd0, 1'(m_rseen), 8'(m_long), 8'(m_short)};
    endfunction

    task automatic strobe(input bit v, input int extra);
        @(posedge clk); #1;
        bus.btn_stb = 1'b1;
        bus.btn_val = v;
        model_strobe(v);
        @(posedge clk); #1;
        bus.btn_stb = 1'b0;
        bus.btn_val = 1'($urandom_range(0, 1));
        repeat (extra) @(posedge clk);
    endtask

    task automatic strobes(input bit v, input int cnt);
        for (int i = 0; i < cnt; i++) strobe(v, 0);
    endtask

    task automatic bus_read(input bit addr);
        repeat (3) @(posedge clk);
        exp_rd_q.push_back({1'b1, addr ? m_addr1() : m_addr0()});
        @(posedge clk); #1;
        bus.wb_cyc = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = addr;
        @(posedge clk); #1;
        bus.wb_cyc = 1'b0;
    endtask

    task automatic bus_write(input bit addr);
        repeat (3) @(posedge clk);
        exp_rd_q.push_back(33'd0);
        if (addr) begin
            m_short = 0; m_long = 0; m_rseen = 0;
        end
        @(posedge clk); #1;
        bus.wb_cyc = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = addr;
        bus.wb_wdata = $urandom;
        @(posedge clk); #1;
        bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
    endtask

    // monitor: pop and compare on every event pulse and every ack
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.evt_short || bus.evt_long || bus.rst_req) begin
                logic [1:0] code;
                logic [1:0] want;
                check("evt_onehot",
                      32'({31'd0, ($countones({bus.evt_short, bus.evt_long, bus.rst_req}) <= 1)}),
                      32'd1);
                code = bus.evt_short ? 2'd1 : (bus.evt_long ? 2'd2 : 2'd3);
                want = 2'd0;
                if (exp_q.size() != 0) want = exp_q.pop_front();
                check("evt_code", 32'(code), 32'(want));
            end
            if (bus.wb_ack) begin
                logic [32:0] item;
                item = 33'h1_dead_beef;
                if (exp_rd_q.size() != 0) item = exp_rd_q.pop_front();
                check("ack_expected", 32'(exp_rd_q.size() + 1 > 0 && item != 33'h1_dead_beef), 32'd1);
                if (item[32]) check("rdata", bus.wb_rdata, item[31:0]);
            end else begin
                check("rdata_idle", bus.wb_rdata, 32'd0);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int hl;
        rst = 1'b1;
        bus.btn_val = 1'b0; bus.btn_stb = 1'b0;
        bus.wb_addr = 1'b0; bus.wb_wdata = 32'd0; bus.wb_we = 1'b0; bus.wb_cyc = 1'b0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check("rst_btn_state", 32'(bus.btn_state), 32'd0);
        check("rst_events", 32'({bus.evt_short, bus.evt_long, bus.rst_req}), 32'd0);
        check("rst_ack", 32'(bus.wb_ack), 32'd0);
        check("rst_rdata", bus.wb_rdata, 32'd0);
        check("rst_fsm", 32'(bus.dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(1'b0);
        bus_read(1'b1);

        // glitch shorter than the debounce length
        strobes(1'b1, DB_LEN - 1);
        check("glitch_state", 32'(bus.btn_state), 32'd0);
        strobes(1'b0, DB_LEN);
        bus_read(1'b1);

        // short press
        strobes(1'b1, DB_LEN);
        check("press_state", 32'(bus.btn_state), 32'd1);
        strobes(1'b1, 20);
        strobes(1'b0, DB_LEN);
        bus_read(1'b1);

        // long press with a mid-hold read
        strobes(1'b1, DB_LEN + 1200);
        bus_read(1'b0);
        strobes(1'b1, 300);
        strobes(1'b0, DB_LEN);
        bus_read(1'b1);

        // hold through the reset request
        strobes(1'b1, DB_LEN + 4500);
        bus_read(1'b0);
        strobes(1'b1, 500);
        strobes(1'b0, DB_LEN);
        bus_read(1'b1);
        bus_read(1'b0);

        // clear, and writes to address 0 are ignored
        bus_write(1'b0);
        bus_write(1'b1);
        bus_read(1'b1);

        // randomized presses with bounce and gaps between strobes
        for (int p = 0; p < 12; p++) begin
            nb = $urandom_range(0, 5);
            for (int i = 0; i < nb; i++) strobe(1'($urandom_range(0, 1)), 0);
            hl = ($urandom_range(0, 3) == 0) ? $urandom_range(995, 1010) : $urandom_range(DB_LEN, 40);
            for (int i = 0; i < hl; i++) strobe(1'b1, $urandom_range(0, 1));
            nb = $urandom_range(0, 5);
            for (int i = 0; i < nb; i++) strobe(1'($urandom_range(0, 1)), 0);
            strobes(1'b0, DB_LEN + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) bus_read(1'($urandom_range(0, 1)));
        end

        // short counter saturation
        for (int p = 0; p < 300; p++) begin
            strobes(1'b1, DB_LEN + 1);
            strobes(1'b0, DB_LEN);
        end
        bus_read(1'b1);

        // clear landing in the same cycle as an evt_short pulse: event wins
        strobes(1'b1, DB_LEN + 2);
        strobes(1'b0, DB_LEN);
        @(posedge clk); #1;
        check("clr_evt_align", 32'(bus.evt_short), 32'd1);
        exp_rd_q.push_back(33'd0);
        bus.wb_cyc = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = 1'b1; bus.wb_wdata = $urandom;
        m_short = 1; m_long = 0; m_rseen = 0;
        @(posedge clk); #1;
        bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
        bus_read(1'b1);

        // asynchronous reset while in LONG with the button still pressed
        strobes(1'b1, DB_LEN + 1100);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_btn_state", 32'(bus.btn_state), 32'd0);
        check("arst_events", 32'({bus.evt_short, bus.evt_long, bus.rst_req}), 32'd0);
        check("arst_ack_rdata", 32'(bus.wb_ack) | bus.wb_rdata, 32'd0);
        check("arst_fsm", 32'(bus.dbg_state), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        strobes(1'b1, DB_LEN - 1);
        check("arst_relock_early", 32'(bus.btn_state), 32'd0);
        strobes(1'b1, 1);
        check("arst_relock", 32'(bus.btn_state), 32'd1);
        strobes(1'b1, 5);
        strobes(1'b0, DB_LEN);
        bus_read(1'b1);
        bus_read(1'b0);

        repeat (10) @(posedge clk);
        check("evt_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
